// File: rtl/wb_arb_pkg.sv
// Shared types and bus widths for the Wishbone slave arbiter.
//   arb_state_e : arbiter FSM states (IDLE, OWN, TERR)
//   *_W         : data, address, select, tag and watchdog widths
package wb_arb_pkg;

    localparam int unsigned DAT_W  = 64;
    localparam int unsigned ADR_W  = 64;
    localparam int unsigned SEL_W  = 8;
    localparam int unsigned TGA_W  = 16;
    localparam int unsigned WDOG_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TERR = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker.
//   req  : request vector, one bit per master
//   last : index of the previous owner; the search starts just above it
//   gnt  : one-hot winner (all zero when nothing is requested)
//   idx  : binary index of the winner
module wb_rr_picker #(
    parameter int unsigned NUM_M = 4,
    localparam int unsigned IW   = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [NUM_M-1:0] gnt,
    output logic [IW-1:0]    idx
);

    int unsigned k;
    logic        found;

    // First requester at or after last+1, wrapping modulo NUM_M.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int unsigned i = 1; i <= NUM_M; i++) begin
            k = (32'(last) + i) % NUM_M;
            if (!found && req[k[IW-1:0]]) begin
                found           = 1'b1;
                gnt[k[IW-1:0]]  = 1'b1;
                idx             = k[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/wb_slave_arbiter.sv
// Round-robin arbiter giving NUM_M Wishbone masters access to one slave,
// with bus lock support and a stalled-strobe watchdog that forces an error.
//   m_*_i  : packed per-master CYC/STB/WE/LOCK/ADR/DAT/SEL/TGA
//   m_*_o  : per-master ACK/ERR/RTY (owner only) and broadcast read data
//   s_*_o  : shared slave request signals, muxed from the owner
//   s_*_i  : slave terminations and read data
//   gnt_o  : registered one-hot grant
module wb_slave_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_M   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_M-1:0]         m_cyc_i,
    input  logic [NUM_M-1:0]         m_stb_i,
    input  logic [NUM_M-1:0]         m_we_i,
    input  logic [NUM_M-1:0]         m_lock_i,
    input  logic [NUM_M*ADR_W-1:0]   m_adr_i,
    input  logic [NUM_M*DAT_W-1:0]   m_dat_i,
    input  logic [NUM_M*SEL_W-1:0]   m_sel_i,
    input  logic [NUM_M*TGA_W-1:0]   m_tga_i,
    output logic [NUM_M-1:0]         m_ack_o,
    output logic [NUM_M-1:0]         m_err_o,
    output logic [NUM_M-1:0]         m_rty_o,
    output logic [DAT_W-1:0]         m_dat_o,
    output logic                     s_cyc_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic                     s_lock_o,
    output logic [ADR_W-1:0]         s_adr_o,
    output logic [DAT_W-1:0]         s_dat_o,
    output logic [SEL_W-1:0]         s_sel_o,
    output logic [TGA_W-1:0]         s_tga_o,
    input  logic                     s_ack_i,
    input  logic                     s_err_i,
    input  logic                     s_rty_i,
    input  logic [DAT_W-1:0]         s_dat_i,
    output logic [NUM_M-1:0]         gnt_o
);

    localparam int unsigned IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    arb_state_e         state, state_n;
    logic [IW-1:0]      owner, owner_n;
    logic [IW-1:0]      last_owner, last_n;
    logic [NUM_M-1:0]   gnt, gnt_n;
    logic [WDOG_W-1:0]  wdog, wdog_n;

    logic [NUM_M-1:0]   pick_gnt;
    logic [IW-1:0]      pick_idx;

    logic               own_cyc, own_stb, own_we, own_lock;
    logic [ADR_W-1:0]   own_adr;
    logic [DAT_W-1:0]   own_dat;
    logic [SEL_W-1:0]   own_sel;
    logic [TGA_W-1:0]   own_tga;
    logic               bus_on, term, stalled;

    wb_rr_picker #(.NUM_M(NUM_M)) u_picker (
        .req  (m_cyc_i),
        .last (last_owner),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    // Select the current owner's request signals.
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_lock = 1'b0;
        own_adr  = '0;
        own_dat  = '0;
        own_sel  = '0;
        own_tga  = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (owner == IW'(i)) begin
                own_cyc  = m_cyc_i[i];
                own_stb  = m_stb_i[i];
                own_we   = m_we_i[i];
                own_lock = m_lock_i[i];
                own_adr  = m_adr_i[i*ADR_W +: ADR_W];
                own_dat  = m_dat_i[i*DAT_W +: DAT_W];
                own_sel  = m_sel_i[i*SEL_W +: SEL_W];
                own_tga  = m_tga_i[i*TGA_W +: TGA_W];
            end
        end
    end

    // Bus is only driven while owned; TERR blanks it and swallows terminations.
    assign bus_on   = (state == OWN);
    assign term     = s_ack_i | s_err_i | s_rty_i;
    assign stalled  = bus_on & own_stb & ~term;

    assign s_cyc_o  = bus_on & own_cyc;
    assign s_stb_o  = bus_on & own_stb;
    assign s_we_o   = bus_on & own_we;
    assign s_lock_o = bus_on & own_lock;
    assign s_adr_o  = bus_on ? own_adr : '0;
    assign s_dat_o  = bus_on ? own_dat : '0;
    assign s_sel_o  = bus_on ? own_sel : '0;
    assign s_tga_o  = bus_on ? own_tga : '0;

    assign m_ack_o  = (bus_on && s_ack_i) ? gnt : '0;
    assign m_rty_o  = (bus_on && s_rty_i) ? gnt : '0;
    assign m_err_o  = ((bus_on && s_err_i) || (state == TERR)) ? gnt : '0;
    assign m_dat_o  = s_dat_i;
    assign gnt_o    = gnt;

    // Next-state logic: arbitration, release and watchdog.
    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last_owner;
        gnt_n   = gnt;
        wdog_n  = wdog;
        case (state)
            IDLE: begin
                if (|m_cyc_i) begin
                    state_n = OWN;
                    owner_n = pick_idx;
                    gnt_n   = pick_gnt;
                end
            end
            OWN: begin
                if (!own_cyc && !own_lock) begin
                    state_n = IDLE;
                    last_n  = owner;
                    gnt_n   = '0;
                    wdog_n  = '0;
                end else if (stalled) begin
                    if (wdog == WDOG_W'(TIMEOUT)) begin
                        state_n = TERR;
                        wdog_n  = '0;
                    end else begin
                        wdog_n  = wdog + WDOG_W'(1);
                    end
                end else begin
                    wdog_n = '0;
                end
            end
            TERR: begin
                state_n = OWN;
                wdog_n  = '0;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                wdog_n  = '0;
            end
        endcase
    end

    // State and arbitration registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(NUM_M - 1);
            gnt        <= '0;
            wdog       <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_n;
            gnt        <= gnt_n;
            wdog       <= wdog_n;
        end
    end

endmodule

// File: tb/tb_wb_slave_arbiter.sv
// Self-checking bench for wb_slave_arbiter (NUM_M=4, TIMEOUT=4).
module tb_wb_slave_arbiter;

    localparam int NM = 4;
    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NM-1:0]     m_cyc, m_stb, m_we, m_lock;
    logic [NM*64-1:0]  m_adr, m_dat;
    logic [NM*8-1:0]   m_sel;
    logic [NM*16-1:0]  m_tga;
    logic [NM-1:0]     m_ack, m_err, m_rty;
    logic [63:0]       rd_dat;
    logic              s_cyc, s_stb, s_we, s_lock;
    logic [63:0]       s_adr, s_dat;
    logic [7:0]        s_sel;
    logic [15:0]       s_tga;
    logic              s_ack, s_err, s_rty;
    logic [63:0]       s_rdat;
    logic [NM-1:0]     gnt;

    wb_slave_arbiter #(.NUM_M(NM), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_lock_i(m_lock),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_tga_i(m_tga),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty), .m_dat_o(rd_dat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_lock_o(s_lock),
        .s_adr_o(s_adr), .s_dat_o(s_dat), .s_sel_o(s_sel), .s_tga_o(s_tga),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_dat_i(s_rdat),
        .gnt_o(gnt)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, whether this is the forced-error
    // cycle, and how many consecutive stalled strobe cycles have elapsed.
    int mo_owner, mo_last, mo_stall;
    bit mo_err;

    task automatic model_next(output int no, output int nl, output int ns, output bit ne);
        bit stalled;
        no = mo_owner; nl = mo_last; ns = mo_stall; ne = mo_err;
        stalled = (mo_owner >= 0) && !mo_err && (1'((m_stb >> mo_owner) & 1) == 1'b1)
                  && !(s_ack || s_err || s_rty);
        if (mo_owner < 0) begin
            for (int k = 1; k <= NM; k++) begin
                int c;
                c = (mo_last + k) % NM;
                if (no < 0 && 1'((m_cyc >> c) & 1) == 1'b1) no = c;
            end
            ns = 0;
        end else if (mo_err) begin
            ne = 1'b0;
            ns = 0;
        end else if (1'((m_cyc >> mo_owner) & 1) == 1'b0 && 1'((m_lock >> mo_owner) & 1) == 1'b0) begin
            nl = mo_owner;
            no = -1;
            ns = 0;
        end else if (stalled) begin
            if (mo_stall >= TO) begin
                ne = 1'b1;
                ns = 0;
            end else begin
                ns = mo_stall + 1;
            end
        end else begin
            ns = 0;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        int no, nl, ns;
        bit ne;
        if (!rst) begin
            mo_owner <= -1;
            mo_last  <= NM - 1;
            mo_stall <= 0;
            mo_err   <= 1'b0;
        end else begin
            model_next(no, nl, ns, ne);
            mo_owner <= no;
            mo_last  <= nl;
            mo_stall <= ns;
            mo_err   <= ne;
        end
    end

    task automatic check_model();
        logic [NM-1:0] eg, eack, eerr, erty;
        logic ecyc, estb, ewe, elock;
        logic [63:0] eadr, edat;
        logic [7:0]  esel;
        logic [15:0] etga;
        eg = '0; eack = '0; eerr = '0; erty = '0;
        ecyc = 1'b0; estb = 1'b0; ewe = 1'b0; elock = 1'b0;
        eadr = '0; edat = '0; esel = '0; etga = '0;
        if (mo_owner >= 0) begin
            eg = NM'(1 << mo_owner);
            if (mo_err) begin
                eerr = eg;
            end else begin
                ecyc  = 1'((m_cyc >> mo_owner) & 1);
                estb  = 1'((m_stb >> mo_owner) & 1);
                ewe   = 1'((m_we >> mo_owner) & 1);
                elock = 1'((m_lock >> mo_owner) & 1);
                eadr  = 64'(m_adr >> (mo_owner * 64));
                edat  = 64'(m_dat >> (mo_owner * 64));
                esel  = 8'(m_sel >> (mo_owner * 8));
                etga  = 16'(m_tga >> (mo_owner * 16));
                eack  = s_ack ? eg : '0;
                eerr  = s_err ? eg : '0;
                erty  = s_rty ? eg : '0;
            end
        end
        chk("gnt",    64'(gnt),    64'(eg));
        chk("s_cyc",  64'(s_cyc),  64'(ecyc));
        chk("s_stb",  64'(s_stb),  64'(estb));
        chk("s_we",   64'(s_we),   64'(ewe));
        chk("s_lock", 64'(s_lock), 64'(elock));
        chk("s_adr",  s_adr,       eadr);
        chk("s_dat",  s_dat,       edat);
        chk("s_sel",  64'(s_sel),  64'(esel));
        chk("s_tga",  64'(s_tga),  64'(etga));
        chk("m_ack",  64'(m_ack),  64'(eack));
        chk("m_err",  64'(m_err),  64'(eerr));
        chk("m_rty",  64'(m_rty),  64'(erty));
        chk("m_dat",  rd_dat,      s_rdat);
    endtask

    task automatic sample();
        @(negedge clk);
        check_model();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus(input int n);
        m_cyc = '0; m_stb = '0; m_we = '0; m_lock = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        for (int i = 0; i < n; i++) begin
            sample();
            adv();
        end
    endtask

    typedef struct {
        logic [NM-1:0] cyc;
        logic          ack;
        logic [NM-1:0] exp_gnt;
        logic          exp_scyc;
        logic [NM-1:0] exp_ack;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NM-1:0] flip;
        int mode;

        vecs[0]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001};
        vecs[2]  = '{4'b1110, 1'b0, 4'b0001, 1'b0, 4'b0000};
        vecs[3]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010};
        vecs[5]  = '{4'b1101, 1'b0, 4'b0010, 1'b0, 4'b0000};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000};
        vecs[7]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100};
        vecs[8]  = '{4'b1011, 1'b0, 4'b0100, 1'b0, 4'b0000};
        vecs[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000};
        vecs[10] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000};
        vecs[11] = '{4'b0111, 1'b0, 4'b1000, 1'b0, 4'b0000};
        vecs[12] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000};
        vecs[13] = '{4'b1111, 1'b0, 4'b0001, 1'b1, 4'b0000};
        vecs[14] = '{4'b1110, 1'b0, 4'b0001, 1'b0, 4'b0000};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};

        rst = 1'b0;
        m_cyc = '1; m_stb = '1; m_we = '1; m_lock = '0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_tga = '0;
        s_ack = 1'b1; s_err = 1'b0; s_rty = 1'b0; s_rdat = 64'h0123_4567_89AB_CDEF;

        // Reset state, with requests and a slave ack present.
        #3;
        chk("rst_gnt",   64'(gnt),   64'(0));
        chk("rst_s_cyc", 64'(s_cyc), 64'(0));
        chk("rst_s_stb", 64'(s_stb), 64'(0));
        chk("rst_m_ack", 64'(m_ack), 64'(0));
        chk("rst_m_dat", rd_dat, 64'h0123_4567_89AB_CDEF);
        adv();
        adv();
        s_ack = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
        rst = 1'b1;

        // Round-robin order with all four masters requesting.
        for (int i = 0; i < 16; i++) begin
            m_cyc = vecs[i].cyc;
            m_stb = vecs[i].cyc;
            s_ack = vecs[i].ack;
            sample();
            chk($sformatf("rr%0d_gnt", i),   64'(gnt),   64'(vecs[i].exp_gnt));
            chk($sformatf("rr%0d_s_cyc", i), 64'(s_cyc), 64'(vecs[i].exp_scyc));
            chk($sformatf("rr%0d_m_ack", i), 64'(m_ack), 64'(vecs[i].exp_ack));
            adv();
        end
        idle_bus(1);

        // Master 2 write reaches the slave unchanged; only it sees the ack.
        for (int i = 0; i < NM; i++) begin
            m_adr[i*64 +: 64] = {$urandom, $urandom};
            m_dat[i*64 +: 64] = {$urandom, $urandom};
        end
        m_adr[2*64 +: 64] = 64'h1000;
        m_dat[2*64 +: 64] = 64'hDEAD_BEEF;
        m_sel[2*8 +: 8]   = 8'hFF;
        m_tga[2*16 +: 16] = 16'h00A5;
        m_cyc = 4'b0100; m_stb = 4'b0100; m_we = 4'b0100;
        sample(); chk("wr_idle_gnt", 64'(gnt), 64'(0)); adv();
        sample();
        chk("wr_adr", s_adr, 64'h1000);
        chk("wr_dat", s_dat, 64'hDEAD_BEEF);
        chk("wr_we",  64'(s_we), 64'(1));
        chk("wr_sel", 64'(s_sel), 64'hFF);
        adv();
        s_ack = 1'b1;
        sample(); chk("wr_ack", 64'(m_ack), 64'(4'b0100)); adv();
        idle_bus(2);

        // Master 1 holds lock across dropped cyc while master 0 waits.
        m_cyc = 4'b0010; m_stb = 4'b0010; m_lock = 4'b0010;
        sample(); adv();
        m_cyc = 4'b0011; m_stb = 4'b0011; s_ack = 1'b1;
        sample(); chk("lk_gnt0", 64'(gnt), 64'(4'b0010)); chk("lk_ack", 64'(m_ack), 64'(4'b0010)); adv();
        s_ack = 1'b0; m_cyc = 4'b0001; m_stb = 4'b0001;
        sample(); chk("lk_gnt1", 64'(gnt), 64'(4'b0010)); chk("lk_s_lock", 64'(s_lock), 64'(1)); adv();
        sample(); chk("lk_gnt2", 64'(gnt), 64'(4'b0010)); adv();
        m_lock = 4'b0000;
        sample(); chk("lk_gnt3", 64'(gnt), 64'(4'b0010)); adv();
        sample(); chk("lk_dead", 64'(gnt), 64'(0)); adv();
        sample(); chk("lk_next", 64'(gnt), 64'(4'b0001)); adv();
        s_ack = 1'b1; sample(); adv();
        idle_bus(2);

        // Watchdog: error on the 5th cycle after stb rises, ack in TERR dropped.
        m_cyc = 4'b0010; m_stb = 4'b0010;
        sample(); adv();
        for (int k = 0; k <= 6; k++) begin
            s_ack = (k >= 5);
            sample();
            chk($sformatf("wd%0d_err", k), 64'(m_err), (k == 5) ? 64'(4'b0010) : 64'(0));
            if (k == 5) begin
                chk("wd_terr_ack", 64'(m_ack), 64'(0));
                chk("wd_terr_stb", 64'(s_stb), 64'(0));
            end
            if (k == 6) chk("wd_ack_after", 64'(m_ack), 64'(4'b0010));
            adv();
        end
        idle_bus(2);

        // Retry to master 3 only; grant kept while cyc high.
        m_cyc = 4'b1000; m_stb = 4'b1000;
        sample(); adv();
        s_rty = 1'b1;
        sample();
        chk("rty_m_rty", 64'(m_rty), 64'(4'b1000));
        chk("rty_m_ack", 64'(m_ack), 64'(0));
        adv();
        s_rty = 1'b0;
        sample(); chk("rty_gnt", 64'(gnt), 64'(4'b1000)); adv();
        idle_bus(2);

        // Asynchronous reset mid-transfer, then master 0 wins a 4-way tie.
        m_cyc = 4'b1111; m_stb = 4'b1111;
        sample(); adv();
        sample(); adv();
        sample(); chk("ar_pre_stb", 64'(s_stb), 64'(1));
        #2;
        rst = 1'b0; s_ack = 1'b1;
        #1;
        chk("ar_gnt",   64'(gnt),   64'(0));
        chk("ar_s_stb", 64'(s_stb), 64'(0));
        chk("ar_s_cyc", 64'(s_cyc), 64'(0));
        chk("ar_s_adr", s_adr, 64'(0));
        chk("ar_m_ack", 64'(m_ack), 64'(0));
        s_ack = 1'b0;
        adv();
        rst = 1'b1;
        sample(); chk("ar_idle", 64'(gnt), 64'(0)); adv();
        sample(); chk("ar_tie", 64'(gnt), 64'(4'b0001)); adv();
        idle_bus(2);

        // Randomized traffic against the reference model.
        m_cyc = '0; m_lock = '0;
        for (int n = 0; n < 1500; n++) begin
            mode = (n / 40) % 3;
            flip = NM'($urandom & $urandom & $urandom);
            m_cyc = m_cyc ^ flip;
            m_stb = m_cyc & NM'($urandom | $urandom);
            m_we  = NM'($urandom);
            flip  = NM'($urandom & $urandom & $urandom & $urandom);
            m_lock = m_lock ^ flip;
            for (int i = 0; i < NM; i++) begin
                m_adr[i*64 +: 64] = {$urandom, $urandom};
                m_dat[i*64 +: 64] = {$urandom, $urandom};
                m_sel[i*8 +: 8]   = 8'($urandom);
                m_tga[i*16 +: 16] = 16'($urandom);
            end
            s_rdat = {$urandom, $urandom};
            if (mode == 2) begin
                s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
            end else begin
                s_ack = ($urandom_range(3) == 0);
                s_err = ($urandom_range(15) == 0);
                s_rty = ($urandom_range(15) == 0);
            end
            sample();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
